// File: rtl/prog_boot_sequencer.sv
// Boot sequencer for the single-cycle MIPS32 core: streams a program into instruction
// memory, holds the PC clear, runs until HLT or the cycle watchdog, then parks the core.
module prog_boot_sequencer #(
    parameter int          ADDR_W     = 10,
    parameter int          DEPTH      = 1024,
    parameter int          CLR_CYCLES = 2,
    parameter int          TIMEOUT    = 65535,
    parameter logic [5:0]  HLT_OP     = 6'b111111
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic [31:0]       ir,
    output logic              cpu_clr,
    output logic              cpu_en,
    output logic              busy,
    output logic              halted,
    output logic              timeout,
    output logic [ADDR_W:0]   word_count,
    output logic [31:0]       cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLEAR,
        S_RUN,
        S_HALT,
        S_TOUT
    } state_t;

    localparam int              CW        = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [ADDR_W:0] DEPTH_W   = (ADDR_W+1)'(DEPTH);
    localparam logic [31:0]     TIMEOUT_W = 32'(TIMEOUT);

    state_t              r_state;
    logic [CW-1:0]       r_clr_cnt;
    logic                r_ld_ready;
    logic                r_imem_we;
    logic [ADDR_W-1:0]   r_imem_addr;
    logic [31:0]         r_imem_wdata;
    logic                r_cpu_clr;
    logic                r_cpu_en;
    logic                r_busy;
    logic                r_halted;
    logic                r_timeout;
    logic [ADDR_W:0]     r_word_count;
    logic [31:0]         r_cycle_count;

    logic                w_xfer;
    logic                w_hlt;
    logic [ADDR_W:0]     w_wc_next;
    logic [31:0]         w_cc_next;
    logic                w_unused_ir;

    // r_ld_ready is only ever high in LOAD, so it alone qualifies the handshake
    assign w_xfer      = ld_valid & r_ld_ready;
    assign w_hlt       = (ir[31:26] == HLT_OP);
    assign w_wc_next   = r_word_count + 1'b1;
    assign w_cc_next   = r_cycle_count + 32'd1;
    assign w_unused_ir = ^ir[25:0];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state       <= S_IDLE;
            r_clr_cnt     <= '0;
            r_ld_ready    <= 1'b0;
            r_imem_we     <= 1'b0;
            r_imem_addr   <= '0;
            r_imem_wdata  <= '0;
            r_cpu_clr     <= 1'b1;
            r_cpu_en      <= 1'b0;
            r_busy        <= 1'b0;
            r_halted      <= 1'b0;
            r_timeout     <= 1'b0;
            r_word_count  <= '0;
            r_cycle_count <= '0;
        end else begin
            r_imem_we <= 1'b0;
            case (r_state)
                S_IDLE, S_HALT, S_TOUT: begin
                    if (start) begin
                        r_state       <= S_LOAD;
                        r_ld_ready    <= 1'b1;
                        r_busy        <= 1'b1;
                        r_cpu_clr     <= 1'b1;
                        r_cpu_en      <= 1'b0;
                        r_halted      <= 1'b0;
                        r_timeout     <= 1'b0;
                        r_word_count  <= '0;
                        r_cycle_count <= '0;
                    end
                end
                S_LOAD: begin
                    if (w_xfer) begin
                        r_imem_we    <= 1'b1;
                        r_imem_addr  <= r_word_count[ADDR_W-1:0];
                        r_imem_wdata <= ld_data;
                        r_word_count <= w_wc_next;
                        if (ld_last || (w_wc_next == DEPTH_W)) begin
                            r_state    <= S_CLEAR;
                            r_ld_ready <= 1'b0;
                            r_clr_cnt  <= CW'(CLR_CYCLES - 1);
                        end
                    end
                end
                S_CLEAR: begin
                    if (r_clr_cnt == '0) begin
                        r_state   <= S_RUN;
                        r_cpu_clr <= 1'b0;
                        r_cpu_en  <= 1'b1;
                    end else begin
                        r_clr_cnt <= r_clr_cnt - 1'b1;
                    end
                end
                S_RUN: begin
                    r_cycle_count <= w_cc_next;
                    // HLT takes priority over a watchdog expiry on the same cycle
                    if (w_hlt) begin
                        r_state  <= S_HALT;
                        r_cpu_en <= 1'b0;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                    end else if (w_cc_next == TIMEOUT_W) begin
                        r_state   <= S_TOUT;
                        r_cpu_en  <= 1'b0;
                        r_busy    <= 1'b0;
                        r_timeout <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ld_ready    = r_ld_ready;
    assign imem_we     = r_imem_we;
    assign imem_addr   = r_imem_addr;
    assign imem_wdata  = r_imem_wdata;
    assign cpu_clr     = r_cpu_clr;
    assign cpu_en      = r_cpu_en;
    assign busy        = r_busy;
    assign halted      = r_halted;
    assign timeout     = r_timeout;
    assign word_count  = r_word_count;
    assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_prog_boot_sequencer.sv
// Directed bench for prog_boot_sequencer: load, clear, run/halt, gaps, full depth,
// watchdog and mid-load reset, with hand-computed expectations.
module tb_prog_boot_sequencer;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [31:0] ir;
    logic        cpu_clr;
    logic        cpu_en;
    logic        busy;
    logic        halted;
    logic        timeout;
    logic [10:0] word_count;
    logic [31:0] cycle_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prog_boot_sequencer #(
        .ADDR_W     (10),
        .DEPTH      (1024),
        .CLR_CYCLES (2),
        .TIMEOUT    (20),
        .HLT_OP     (6'b111111)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .ir          (ir),
        .cpu_clr     (cpu_clr),
        .cpu_en      (cpu_en),
        .busy        (busy),
        .halted      (halted),
        .timeout     (timeout),
        .word_count  (word_count),
        .cycle_count (cycle_count)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (2) tick();
        checks++;
        if ({ld_ready, imem_we, imem_addr, imem_wdata, cpu_clr, cpu_en, busy, halted, timeout}
            !== {1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_ctrl got rdy=%b we=%b a=%0d d=%h clr=%b en=%b busy=%b h=%b t=%b",
                     ld_ready, imem_we, imem_addr, imem_wdata, cpu_clr, cpu_en, busy, halted, timeout);
        end
        checks++;
        if ({word_count, cycle_count} !== {11'd0, 32'd0}) begin
            errors++;
            $display("FAIL reset_counts got wc=%0d cc=%0d want 0 0", word_count, cycle_count);
        end
        #2 clr = 1'b0;
        tick();
    endtask

    task automatic test_load;
        logic [31:0] prog [7];
        prog = '{32'h200100c8, 32'h28020001, 32'h14411000, 32'h2c210001,
                 32'h3420fffd, 32'h240200c6, 32'hfc000000};
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({ld_ready, busy, word_count} !== {1'b1, 1'b1, 11'd0}) begin
            errors++;
            $display("FAIL load_enter got rdy=%b busy=%b wc=%0d want 1 1 0", ld_ready, busy, word_count);
        end
        for (int i = 0; i < 7; i++) begin
            ld_valid = 1'b1;
            ld_data  = prog[i];
            ld_last  = (i == 6);
            tick();
            checks++;
            if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 10'(i), prog[i]}) begin
                errors++;
                $display("FAIL load_write[%0d] got we=%b a=%0d d=%h want 1 %0d %h",
                         i, imem_we, imem_addr, imem_wdata, i, prog[i]);
            end
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        checks++;
        if ({word_count, ld_ready, cpu_clr, cpu_en} !== {11'd7, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL load_done got wc=%0d rdy=%b clr=%b en=%b want 7 0 1 0",
                     word_count, ld_ready, cpu_clr, cpu_en);
        end
        tick();
        checks++;
        if ({imem_we, cpu_clr, cpu_en} !== {1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL clear_2nd got we=%b clr=%b en=%b want 0 1 0", imem_we, cpu_clr, cpu_en);
        end
        tick();
        checks++;
        if ({cpu_clr, cpu_en, busy} !== {1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL run_enter got clr=%b en=%b busy=%b want 0 1 1", cpu_clr, cpu_en, busy);
        end
    endtask

    task automatic test_run_halt;
        start = 1'b1;
        for (int k = 0; k < 10; k++) begin
            ir = 32'h20010000 | 32'(k);
            tick();
        end
        checks++;
        if ({cycle_count, cpu_en, ld_ready, busy} !== {32'd10, 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL run_mid got cc=%0d en=%b rdy=%b busy=%b want 10 1 0 1",
                     cycle_count, cpu_en, ld_ready, busy);
        end
        start = 1'b0;
        ir    = 32'hfc000000;
        tick();
        checks++;
        if ({halted, cpu_en, timeout, busy, cpu_clr, cycle_count} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd11}) begin
            errors++;
            $display("FAIL halt got h=%b en=%b t=%b busy=%b clr=%b cc=%0d want 1 0 0 0 0 11",
                     halted, cpu_en, timeout, busy, cpu_clr, cycle_count);
        end
        ir = 32'h0;
        tick();
        checks++;
        if ({halted, cycle_count} !== {1'b1, 32'd11}) begin
            errors++;
            $display("FAIL halt_hold got h=%b cc=%0d want 1 11", halted, cycle_count);
        end
    endtask

    task automatic test_gaps;
        logic pat [7];
        int   n = 0;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            ld_valid = pat[i];
            ld_data  = 32'ha0 + 32'(i);
            ld_last  = (i == 6);
            tick();
            checks++;
            if (pat[i]) begin
                if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 10'(n), 32'ha0 + 32'(i)}) begin
                    errors++;
                    $display("FAIL gap_write[%0d] got we=%b a=%0d d=%h want 1 %0d %h",
                             i, imem_we, imem_addr, imem_wdata, n, 32'ha0 + 32'(i));
                end
            end else if (imem_we !== 1'b0) begin
                errors++;
                $display("FAIL gap_idle[%0d] got we=%b want 0", i, imem_we);
            end
            if (imem_we === 1'b1) n++;
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        checks++;
        if ({n[3:0], word_count} !== {4'd4, 11'd4}) begin
            errors++;
            $display("FAIL gap_count got pulses=%0d wc=%0d want 4 4", n, word_count);
        end
        ir = 32'hfc000000;
        repeat (3) tick();
        checks++;
        if ({halted, cycle_count} !== {1'b1, 32'd1}) begin
            errors++;
            $display("FAIL gap_halt got h=%b cc=%0d want 1 1", halted, cycle_count);
        end
        ir = 32'h0;
    endtask

    task automatic test_depth;
        int bad = 0;
        start = 1'b1;
        tick();
        start    = 1'b0;
        ld_valid = 1'b1;
        ld_last  = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            ld_data = 32'h10000000 + 32'(i * 7);
            tick();
            if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 10'(i), 32'h10000000 + 32'(i * 7)}) begin
                if (bad < 4)
                    $display("FAIL depth_write[%0d] got we=%b a=%0d d=%h", i, imem_we, imem_addr, imem_wdata);
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL depth_writes got %0d bad words want 0", bad);
        end
        checks++;
        if ({ld_ready, word_count, cpu_clr, busy, imem_addr} !== {1'b0, 11'd1024, 1'b1, 1'b1, 10'd1023}) begin
            errors++;
            $display("FAIL depth_end got rdy=%b wc=%0d clr=%b busy=%b a=%0d want 0 1024 1 1 1023",
                     ld_ready, word_count, cpu_clr, busy, imem_addr);
        end
        ld_data = 32'hdeadbeef;
        tick();
        checks++;
        if ({imem_we, word_count, cpu_clr, cpu_en} !== {1'b0, 11'd1024, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL depth_extra got we=%b wc=%0d clr=%b en=%b want 0 1024 1 0",
                     imem_we, word_count, cpu_clr, cpu_en);
        end
        ld_valid = 1'b0;
        ir       = 32'hfc000000;
        repeat (2) tick();
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL depth_halt got h=%b want 1", halted);
        end
        ir = 32'h0;
    endtask

    task automatic load_one_and_run;
        start = 1'b1;
        tick();
        start    = 1'b0;
        ld_valid = 1'b1;
        ld_data  = 32'h00001234;
        ld_last  = 1'b1;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_timeout;
        ir = 32'h0;
        load_one_and_run();
        repeat (19) tick();
        checks++;
        if ({timeout, cpu_en, cycle_count} !== {1'b0, 1'b1, 32'd19}) begin
            errors++;
            $display("FAIL tout_pre got t=%b en=%b cc=%0d want 0 1 19", timeout, cpu_en, cycle_count);
        end
        tick();
        checks++;
        if ({timeout, halted, cpu_en, busy, cycle_count} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'd20}) begin
            errors++;
            $display("FAIL tout got t=%b h=%b en=%b busy=%b cc=%0d want 1 0 0 0 20",
                     timeout, halted, cpu_en, busy, cycle_count);
        end
        load_one_and_run();
        repeat (19) tick();
        ir = 32'hfc000000;
        tick();
        checks++;
        if ({halted, timeout, cpu_en, cycle_count} !== {1'b1, 1'b0, 1'b0, 32'd20}) begin
            errors++;
            $display("FAIL tout_hlt_tie got h=%b t=%b en=%b cc=%0d want 1 0 0 20",
                     halted, timeout, cpu_en, cycle_count);
        end
        ir = 32'h0;
    endtask

    task automatic test_clr_midload;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1;
            ld_data  = 32'hc0 + 32'(i);
            tick();
        end
        ld_valid = 1'b0;
        checks++;
        if ({word_count, imem_we} !== {11'd3, 1'b1}) begin
            errors++;
            $display("FAIL clr_pre got wc=%0d we=%b want 3 1", word_count, imem_we);
        end
        #2 clr = 1'b1;
        #1;
        checks++;
        if ({ld_ready, imem_we, imem_addr, imem_wdata, cpu_clr, cpu_en, busy, halted, timeout,
             word_count, cycle_count} !==
            {1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 32'd0}) begin
            errors++;
            $display("FAIL clr_async got rdy=%b we=%b a=%0d d=%h clr=%b en=%b busy=%b wc=%0d",
                     ld_ready, imem_we, imem_addr, imem_wdata, cpu_clr, cpu_en, busy, word_count);
        end
        #1 clr = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1;
            ld_data  = 32'he0 + 32'(i);
            ld_last  = (i == 1);
            tick();
            checks++;
            if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 10'(i), 32'he0 + 32'(i)}) begin
                errors++;
                $display("FAIL reload_write[%0d] got we=%b a=%0d d=%h want 1 %0d %h",
                         i, imem_we, imem_addr, imem_wdata, i, 32'he0 + 32'(i));
            end
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        checks++;
        if (word_count !== 11'd2) begin
            errors++;
            $display("FAIL reload_wc got %0d want 2", word_count);
        end
    endtask

    initial begin
        clr      = 1'b1;
        start    = 1'b0;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        ld_data  = 32'h0;
        ir       = 32'h0;
        test_reset();
        test_load();
        test_run_halt();
        test_gaps();
        test_depth();
        test_timeout();
        test_clr_midload();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
